// File: rtl/display_scan_driver_pkg.sv
// Shared alarm-clock display definitions.
// Holds the display geometry, the digit-index type and the segment bit order
// used on the 28-bit segment bus. It also provides two helpers:
//   digit_segs  - pulls one digit's 7 segments out of the bus
//   anode_sel_n - one-hot-low anode pattern for a digit index
package display_scan_driver_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;
    localparam int SEG_BUS_W  = NUM_DIGITS * SEG_W;

    typedef logic [1:0] digit_t;

    localparam digit_t LAST_DIGIT = 2'd3;

    // Segment bit positions inside one 7-bit digit field.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Digit i occupies bus[7i+6:7i]; digit 0 is the rightmost digit.
    function automatic logic [SEG_W-1:0] digit_segs(input logic [SEG_BUS_W-1:0] bus,
                                                    input digit_t d);
        logic [SEG_W-1:0] r;
        r = bus[6:0];
        case (d)
            2'd0: r = bus[6:0];
            2'd1: r = bus[13:7];
            2'd2: r = bus[20:14];
            2'd3: r = bus[27:21];
            default: r = bus[6:0];
        endcase
        return r;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] anode_sel_n(input digit_t d);
        logic [NUM_DIGITS-1:0] r;
        r    = '1;
        r[d] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/display_scan_driver_scan_timer.sv
// Scan timing for the 4-digit multiplexed display.
// Produces the slot position, the active digit, the PWM phase and the
// frame-level blink phase.
// Ports:
//   clk, reset   - system clock, asynchronous active-high reset
//   blink_en     - blink request latched for the current frame
//   digit        - digit whose slot is running
//   pwm_cnt      - PWM phase inside the ON part of the slot
//   slot_start   - first cycle of a digit slot (divider at 0)
//   on_phase     - slot is past its blank interval
//   frame_end    - last cycle of digit 3's slot
//   blink_phase  - 1 while the current blink half-period is the dark one
module scan_timer
    import display_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 50,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       blink_en,
    output digit_t     digit,
    output logic [2:0] pwm_cnt,
    output logic       slot_start,
    output logic       on_phase,
    output logic       frame_end,
    output logic       blink_phase
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [FRM_W-1:0] frame_cnt;
    logic             slot_end;

    assign slot_end   = (div_cnt == DIV_LAST);
    assign slot_start = (div_cnt == '0);
    assign on_phase   = (div_cnt >= BLANK_END);
    assign frame_end  = slot_end && (digit == LAST_DIGIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            digit   <= '0;
            pwm_cnt <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            digit   <= digit + 2'd1;
            pwm_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (on_phase) begin
                pwm_cnt <= pwm_cnt + 3'd1;
            end
        end
    end

    // Held at zero whenever blinking is off, so a fresh blink request always
    // begins with a visible half-period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!blink_en) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FRM_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scan_driver.sv
// Multiplexed driver for a 4-digit common-anode 7-segment display.
// Each digit slot starts with an all-off blank interval, then lights the
// digit under 3-bit PWM. The segment bus and blink request are snapshotted
// once per frame so a frame never mixes old and new data.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   segIn       - active-high segments, digit i at [7i+6:7i]
//   blink       - blink request
//   brightness  - lit for (brightness+1)/8 of the ON phase
//   segOut_n    - active-low segments of the current digit
//   anode_n     - active-low digit enables, at most one low
//   frameStart  - one-cycle pulse when outputs first show digit 0's slot
module display_scan_driver
    import display_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 50,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [27:0] segIn,
    input  logic        blink,
    input  logic [2:0]  brightness,
    output logic [6:0]  segOut_n,
    output logic [3:0]  anode_n,
    output logic        frameStart
);

    digit_t               digit;
    logic [2:0]           pwm_cnt;
    logic                 slot_start;
    logic                 on_phase;
    logic                 frame_end;
    logic                 blink_phase;
    logic [SEG_BUS_W-1:0] seg_snap;
    logic                 blink_snap;
    logic                 frame_seen;
    logic                 lit;

    scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_scan_timer (
        .clk         (clk),
        .reset       (reset),
        .blink_en    (blink_snap),
        .digit       (digit),
        .pwm_cnt     (pwm_cnt),
        .slot_start  (slot_start),
        .on_phase    (on_phase),
        .frame_end   (frame_end),
        .blink_phase (blink_phase)
    );

    // blink_snap gates blink_phase: when blinking stops, the frame that
    // follows is visible even though blink_phase clears one cycle later.
    assign lit = on_phase && (pwm_cnt <= brightness) && !(blink_snap && blink_phase);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_snap   <= '0;
            blink_snap <= 1'b0;
            frame_seen <= 1'b0;
        end else if (frame_end) begin
            seg_snap   <= segIn;
            blink_snap <= blink;
            frame_seen <= 1'b1;
        end
    end

    // Outputs are registered straight from the timer state, so the pins lag
    // the internal slot position by one cycle. frame_seen keeps frameStart
    // quiet on the first (snapshot-less) frame after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode_n    <= 4'b1111;
            segOut_n   <= 7'h7F;
            frameStart <= 1'b0;
        end else begin
            frameStart <= slot_start && (digit == 2'd0) && frame_seen;
            if (lit) begin
                anode_n  <= anode_sel_n(digit);
                segOut_n <= ~digit_segs(seg_snap, digit);
            end else begin
                anode_n  <= 4'b1111;
                segOut_n <= 7'h7F;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// Bench for display_scan_driver. Three instances share the inputs:
//   a: SCAN_DIV=8,  BLANK_CYCLES=2, BLINK_FRAMES=2 (32-cycle frame)
//   b: SCAN_DIV=18, BLANK_CYCLES=2, BLINK_FRAMES=2 (72-cycle frame)
//   c: SCAN_DIV=3,  BLANK_CYCLES=2, BLINK_FRAMES=2 (12-cycle frame)
// After a release, pins seen after edge e reflect slot position s = e-1.
module tb_display_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [27:0] seg_in;
    logic        blink;
    logic [2:0]  brightness;

    logic [6:0] seg_a, seg_b, seg_c;
    logic [3:0] an_a, an_b, an_c;
    logic       fs_a, fs_b, fs_c;

    int errors = 0;
    int checks = 0;
    int ecount = 0;
    int lit;

    // digit3..digit0 = 06, 5B, 4F, 66
    localparam logic [27:0] PAT1 = {7'h06, 7'h5B, 7'h4F, 7'h66};
    // digit3..digit0 = 3F, 7F, 6D, 07
    localparam logic [27:0] PAT2 = {7'h3F, 7'h7F, 7'h6D, 7'h07};

    always #5 clk = ~clk;

    display_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2), .BLINK_FRAMES(2)) u_dut_a (
        .clk(clk), .reset(reset), .segIn(seg_in), .blink(blink), .brightness(brightness),
        .segOut_n(seg_a), .anode_n(an_a), .frameStart(fs_a)
    );

    display_scan_driver #(.SCAN_DIV(18), .BLANK_CYCLES(2), .BLINK_FRAMES(2)) u_dut_b (
        .clk(clk), .reset(reset), .segIn(seg_in), .blink(blink), .brightness(brightness),
        .segOut_n(seg_b), .anode_n(an_b), .frameStart(fs_b)
    );

    display_scan_driver #(.SCAN_DIV(3), .BLANK_CYCLES(2), .BLINK_FRAMES(2)) u_dut_c (
        .clk(clk), .reset(reset), .segIn(seg_in), .blink(blink), .brightness(brightness),
        .segOut_n(seg_c), .anode_n(an_c), .frameStart(fs_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    // Walks n cycles on one instance, checking anode, segments and frameStart
    // against the slot position derived from ecount. pat is the frame
    // snapshot expected on screen, sup marks a blink-dark frame.
    task automatic check_range(input int sel, input int n, input logic [27:0] pat,
                               input bit sup, output int lit_cnt);
        int d, b, s, dv, dg, pwm, multi;
        logic [3:0] an, ea;
        logic [6:0] sg, es;
        logic       f, ef;
        d = (sel == 0) ? 8 : (sel == 1) ? 18 : 3;
        b = 2;
        lit_cnt = 0;
        multi = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            s  = ecount - 1;
            dv = s % d;
            dg = (s / d) % 4;
            ea = 4'hF;
            es = 7'h7F;
            if (dv >= b && !sup) begin
                pwm = (dv - b) % 8;
                if (pwm <= int'(brightness)) begin
                    ea[dg] = 1'b0;
                    es = ~pat[dg*7 +: 7];
                end
            end
            ef = (dv == 0) && (dg == 0) && (s >= 4 * d);
            case (sel)
                0: begin an = an_a; sg = seg_a; f = fs_a; end
                1: begin an = an_b; sg = seg_b; f = fs_b; end
                default: begin an = an_c; sg = seg_c; f = fs_c; end
            endcase
            check($sformatf("anode_n[%0d] s=%0d", sel, s), 32'(an), 32'(ea));
            check($sformatf("segOut_n[%0d] s=%0d", sel, s), 32'(sg), 32'(es));
            check($sformatf("frameStart[%0d] s=%0d", sel, s), 32'(f), 32'(ef));
            if (an != 4'hF) lit_cnt++;
            if ($countones(~an) > 1) multi++;
        end
        check($sformatf("single_anode[%0d]", sel), 32'(multi), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        ecount = 0;
    endtask

    initial begin
        reset      = 1'b1;
        seg_in     = PAT1;
        blink      = 1'b0;
        brightness = 3'd7;
        tick();
        tick();
        check("reset anode_n a", 32'(an_a), 32'hF);
        check("reset segOut_n a", 32'(seg_a), 32'h7F);
        check("reset frameStart a", 32'(fs_a), 32'h0);
        check("reset anode_n b", 32'(an_b), 32'hF);
        check("reset anode_n c", 32'(an_c), 32'hF);
        reset  = 1'b0;
        ecount = 0;

        // Scan order: first frame dark, then PAT1 digit by digit.
        check_range(0, 32, 28'h0, 1'b0, lit);
        check_range(0, 32, PAT1, 1'b0, lit);
        check("lit cycles frame2 a", 32'(lit), 32'd24);

        // No tearing: segIn changes during digit 1's slot of frame 3.
        check_range(0, 12, PAT1, 1'b0, lit);
        seg_in = PAT2;
        check_range(0, 20, PAT1, 1'b0, lit);
        check_range(0, 32, PAT2, 1'b0, lit);

        // Reset while digit 2 is lit in frame 5.
        check_range(0, 19, PAT2, 1'b0, lit);
        check("digit2 lit anode_n", 32'(an_a), 32'hB);
        check("digit2 lit segOut_n", 32'(seg_a), 32'h00);
        reset = 1'b1;
        tick();
        check("midslot reset anode_n", 32'(an_a), 32'hF);
        check("midslot reset segOut_n", 32'(seg_a), 32'h7F);
        reset  = 1'b0;
        ecount = 0;
        check_range(0, 32, 28'h0, 1'b0, lit);
        check_range(0, 32, PAT2, 1'b0, lit);

        // Blink: two visible frames, two dark, drop and re-request.
        seg_in = PAT1;
        blink  = 1'b1;
        do_reset();
        check_range(0, 32, 28'h0, 1'b0, lit);
        check_range(0, 32, PAT1, 1'b0, lit);
        check_range(0, 32, PAT1, 1'b0, lit);
        check("blink visible lit", 32'(lit), 32'd24);
        check_range(0, 5, PAT1, 1'b1, lit);
        blink = 1'b0;
        check_range(0, 27, PAT1, 1'b1, lit);
        check("blink dark lit", 32'(lit), 32'd0);
        check_range(0, 32, PAT1, 1'b0, lit);
        check("blink dropped lit", 32'(lit), 32'd24);
        check_range(0, 10, PAT1, 1'b0, lit);
        blink = 1'b1;
        check_range(0, 22, PAT1, 1'b0, lit);
        check_range(0, 32, PAT1, 1'b0, lit);
        check_range(0, 32, PAT1, 1'b0, lit);
        check_range(0, 32, PAT1, 1'b1, lit);
        check("blink restart dark lit", 32'(lit), 32'd0);
        blink = 1'b0;

        // Brightness on the 18-cycle slot instance.
        brightness = 3'd0;
        do_reset();
        check_range(1, 72, 28'h0, 1'b0, lit);
        check_range(1, 72, PAT1, 1'b0, lit);
        check("brightness0 lit", 32'(lit), 32'd8);
        brightness = 3'd3;
        check_range(1, 72, PAT1, 1'b0, lit);
        check("brightness3 lit", 32'(lit), 32'd32);

        // Boundary: one ON cycle per slot.
        brightness = 3'd7;
        do_reset();
        check_range(2, 12, 28'h0, 1'b0, lit);
        check_range(2, 24, PAT1, 1'b0, lit);
        check("boundary lit", 32'(lit), 32'd8);
        brightness = 3'd0;
        check_range(2, 12, PAT1, 1'b0, lit);
        check("boundary brightness0 lit", 32'(lit), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
